// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port unified memory between the fetch stage (instruction
//   reads) and the memory stage (loads/stores). Exactly one transaction is in
//   flight at a time on a req/ack bus with variable latency. Data requests win
//   arbitration, except that after MAX_D_BURST consecutive data grants with a
//   fetch pending, the next grant goes to fetch.
//
//   Parameter
//     MAX_D_BURST  data grants allowed in a row while fetch waits (1..15)
//
//   Ports
//     clk, rst                  clock, synchronous active-high reset
//     if_req/if_addr/if_kill    fetch request (level), address, redirect kill
//     if_rdata/if_valid         fetched instruction, one-cycle completion pulse
//     dm_req/dm_we/dm_addr      data request (level), store flag, address
//     dm_wdata/dm_be            store data and byte enables
//     dm_rdata/dm_valid         load data, one-cycle completion pulse
//     mem_req/mem_we/mem_addr   memory request held until ack, write, address
//     mem_wdata/mem_be          memory write data, byte enables (all ones on reads)
//     mem_ack/mem_rdata         memory completion and read data
//     stall_f/stall_m           combinational stalls for the hazard unit
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned MAX_D_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_kill,
    output logic [31:0] if_rdata,
    output logic        if_valid,

    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_be,
    output logic [31:0] dm_rdata,
    output logic        dm_valid,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,

    output logic        stall_f,
    output logic        stall_m
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;
    localparam int unsigned CW = 4;

    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_D_BURST);
    localparam logic [BW-1:0] BE_ALL    = BW'(4'hF);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   burst_cnt, burst_cnt_nxt;
    logic            kill_flag, kill_flag_nxt;

    logic            mem_req_nxt;
    logic            mem_we_nxt;
    logic [AW-1:0]   mem_addr_nxt;
    logic [DW-1:0]   mem_wdata_nxt;
    logic [BW-1:0]   mem_be_nxt;
    logic            if_valid_nxt;
    logic            dm_valid_nxt;
    logic [DW-1:0]   if_rdata_nxt;
    logic [DW-1:0]   dm_rdata_nxt;

    logic            fetch_starved;
    logic            grant_d;
    logic            grant_i;

    // Fetch has waited through a full data burst: data must yield this time.
    assign fetch_starved = if_req && (burst_cnt == BURST_MAX);

    // Next-state, grant and registered-output logic.
    always_comb begin
        state_nxt     = state;
        burst_cnt_nxt = burst_cnt;
        kill_flag_nxt = kill_flag;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        mem_be_nxt    = mem_be;
        if_rdata_nxt  = if_rdata;
        dm_rdata_nxt  = dm_rdata;
        if_valid_nxt  = 1'b0;
        dm_valid_nxt  = 1'b0;
        grant_d       = 1'b0;
        grant_i       = 1'b0;

        case (state)
            IDLE: begin
                if (dm_req && !fetch_starved) begin
                    grant_d       = 1'b1;
                    state_nxt     = BUSY_D;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = dm_we;
                    mem_addr_nxt  = dm_addr;
                    mem_wdata_nxt = dm_we ? dm_wdata : '0;
                    mem_be_nxt    = dm_we ? dm_be : BE_ALL;
                end else if (if_req && !if_kill) begin
                    grant_i       = 1'b1;
                    state_nxt     = BUSY_I;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = 1'b0;
                    mem_addr_nxt  = if_addr;
                    mem_wdata_nxt = '0;
                    mem_be_nxt    = BE_ALL;
                end
            end

            BUSY_I: begin
                // A redirect anywhere in the fetch, ack cycle included, voids it.
                if (if_kill) begin
                    kill_flag_nxt = 1'b1;
                end
                if (mem_ack) begin
                    mem_req_nxt = 1'b0;
                    state_nxt   = DONE;
                    if (!(kill_flag || if_kill)) begin
                        if_rdata_nxt = mem_rdata;
                        if_valid_nxt = 1'b1;
                    end
                end
            end

            BUSY_D: begin
                if (mem_ack) begin
                    mem_req_nxt  = 1'b0;
                    state_nxt    = DONE;
                    dm_valid_nxt = 1'b1;
                    // Stores leave the last load result in place.
                    if (!mem_we) begin
                        dm_rdata_nxt = mem_rdata;
                    end
                end
            end

            DONE: begin
                state_nxt     = IDLE;
                kill_flag_nxt = 1'b0;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Counts data grants that overtook a waiting fetch; any cycle without
        // a fetch request, or a fetch grant, restarts the count.
        if (!if_req) begin
            burst_cnt_nxt = '0;
        end else if (grant_i) begin
            burst_cnt_nxt = '0;
        end else if (grant_d && (burst_cnt != BURST_MAX)) begin
            burst_cnt_nxt = burst_cnt + CW'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            burst_cnt <= '0;
            kill_flag <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_cnt_nxt;
            kill_flag <= kill_flag_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            mem_be    <= mem_be_nxt;
            if_valid  <= if_valid_nxt;
            dm_valid  <= dm_valid_nxt;
            if_rdata  <= if_rdata_nxt;
            dm_rdata  <= dm_rdata_nxt;
        end
    end

    // Stalls follow the request directly so the pipeline reacts in-cycle.
    assign stall_f = if_req & ~if_valid;
    assign stall_m = dm_req & ~dm_valid;

    // Completion pulses belong to a single requester.
    a_valid_onehot: assert property (@(posedge clk) disable iff (rst)
        !(if_valid && dm_valid));

    // The bus request may not be withdrawn before the memory acknowledges.
    a_req_held: assert property (@(posedge clk) disable iff (rst)
        (mem_req && !mem_ack) |=> mem_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Scoreboard bench for mem_port_arbiter. Requesters push the expected
//   completion data when they issue; a negedge monitor pops and compares on
//   each valid pulse, checks each bus grant against a transaction-level
//   arbitration model, and checks the stall outputs every cycle. A behavioural
//   memory with random latency answers the bus.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int unsigned MAXB = 4;
    localparam int TMO = 200;

    logic        clk;
    logic        rst;
    logic        if_req, if_kill;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall_f, stall_m;

    int tests;
    int errors;

    logic [31:0] exp_if[$];
    logic [31:0] exp_dm[$];
    logic [31:0] ram     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] last_if_q, last_dm_q;

    logic        s_if_req, s_if_kill, s_dm_req, s_dm_we;
    logic [31:0] s_if_addr, s_dm_addr, s_dm_wdata;
    logic [3:0]  s_dm_be;
    int          bcnt;
    logic        prev_mreq, prev_ifv, prev_dmv;
    string       glog;

    int          lat_min, lat_max;
    logic        resp_en, stray_ack;

    mem_port_arbiter #(.MAX_D_BURST(MAXB)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_kill   (if_kill),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_be     (dm_be),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .stall_f   (stall_f),
        .stall_m   (stall_m)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Background contents of untouched memory words.
    function automatic logic [31:0] seed_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return seed_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return seed_word(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Request inputs as seen by the DUT at each rising edge.
    task automatic sampler();
        forever begin
            @(posedge clk);
            s_if_req   = if_req;
            s_if_kill  = if_kill;
            s_if_addr  = if_addr;
            s_dm_req   = dm_req;
            s_dm_we    = dm_we;
            s_dm_addr  = dm_addr;
            s_dm_wdata = dm_wdata;
            s_dm_be    = dm_be;
            if (rst || !if_req) bcnt = 0;
        end
    endtask

    // Memory device: acks a held request after a random number of cycles.
    task automatic responder();
        int lat;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (!resp_en) begin
                mem_ack = stray_ack;
            end else if (mem_req) begin
                lat = int'($urandom_range(lat_max, lat_min));
                repeat (lat) @(negedge clk);
                if (mem_req && resp_en) begin
                    if (mem_we) ram[mem_addr] = merge(ram_rd(mem_addr), mem_wdata, mem_be);
                    mem_rdata = mem_we ? $urandom() : ram_rd(mem_addr);
                    mem_ack   = 1'b1;
                end
            end
        end
    endtask

    // Checks a new bus transaction against the arbitration rules.
    task automatic grant_check();
        logic ed, ei, ad;
        ed = s_dm_req && !(s_if_req && (bcnt == int'(MAXB)));
        ei = !ed && s_if_req && !s_if_kill;
        ad = (mem_addr >= 32'h1000);
        glog = {glog, ad ? "D" : "I"};
        chk("grant_expected", 32'(ed || ei), 32'd1);
        chk("grant_owner_is_data", 32'(ad), 32'(ed));
        if (ed) begin
            chk("g_mem_we",    32'(mem_we), 32'(s_dm_we));
            chk("g_mem_addr",  mem_addr, s_dm_addr);
            chk("g_mem_wdata", mem_wdata, s_dm_we ? s_dm_wdata : 32'd0);
            chk("g_mem_be",    32'(mem_be), s_dm_we ? 32'(s_dm_be) : 32'hF);
            if (s_if_req && bcnt < int'(MAXB)) bcnt++;
        end else begin
            chk("g_mem_we",    32'(mem_we), 32'd0);
            chk("g_mem_addr",  mem_addr, s_if_addr);
            chk("g_mem_wdata", mem_wdata, 32'd0);
            chk("g_mem_be",    32'(mem_be), 32'hF);
            bcnt = 0;
        end
    endtask

    task automatic monitor();
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (if_valid && dm_valid) chk("valid_overlap", 32'(dm_valid), 32'd0);
            if (if_valid) begin
                chk("if_valid_one_cycle", 32'(prev_ifv), 32'd0);
                if (exp_if.size() == 0) begin
                    chk("if_valid_unexpected", 32'(if_valid), 32'd0);
                end else begin
                    e = exp_if.pop_front();
                    chk("if_rdata", if_rdata, e);
                end
            end
            if (dm_valid) begin
                chk("dm_valid_one_cycle", 32'(prev_dmv), 32'd0);
                if (exp_dm.size() == 0) begin
                    chk("dm_valid_unexpected", 32'(dm_valid), 32'd0);
                end else begin
                    e = exp_dm.pop_front();
                    chk("dm_rdata", dm_rdata, e);
                end
            end
            chk("stall_f", 32'(stall_f), 32'(if_req && !if_valid));
            chk("stall_m", 32'(stall_m), 32'(dm_req && !dm_valid));
            if (mem_req && !prev_mreq) grant_check();
            prev_mreq = mem_req;
            prev_ifv  = if_valid;
            prev_dmv  = dm_valid;
        end
    endtask

    // Issue one fetch and hold it until completion; gap 0 keeps if_req high.
    task automatic do_fetch(input logic [31:0] a, input int gap);
        int n;
        if_addr = a;
        if_req  = 1'b1;
        last_if_q = ref_rd(a);
        exp_if.push_back(last_if_q);
        n = 0;
        step();
        while (!if_valid && n < TMO) begin
            step();
            n++;
        end
        if (!if_valid) begin
            chk("fetch_timeout", 32'(if_valid), 32'd1);
            void'(exp_if.pop_back());
        end
        if (gap > 0) begin
            if_req = 1'b0;
            repeat (gap) step();
        end
    endtask

    // Issue one load/store; the reference memory is updated in issue order.
    task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, input int gap);
        int n;
        dm_we    = we;
        dm_addr  = a;
        dm_wdata = wd;
        dm_be    = be;
        dm_req   = 1'b1;
        if (we) begin
            ref_mem[a] = merge(ref_rd(a), wd, be);
        end else begin
            last_dm_q = ref_rd(a);
        end
        exp_dm.push_back(last_dm_q);
        n = 0;
        step();
        while (!dm_valid && n < TMO) begin
            step();
            n++;
        end
        if (!dm_valid) begin
            chk("data_timeout", 32'(dm_valid), 32'd1);
            void'(exp_dm.pop_back());
        end
        if (gap > 0) begin
            dm_req = 1'b0;
            repeat (gap) step();
        end
    endtask

    task automatic wait_mem_req(input logic lvl, input string name);
        int n;
        n = 0;
        while (mem_req !== lvl && n < TMO) begin
            step();
            n++;
        end
        chk(name, 32'(mem_req), 32'(lvl));
    endtask

    initial begin
        tests = 0; errors = 0;
        rst = 1'b1;
        if_req = 1'b0; if_kill = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        resp_en = 1'b1; stray_ack = 1'b0;
        lat_min = 0; lat_max = 0;
        last_if_q = '0; last_dm_q = '0;
        bcnt = 0; prev_mreq = 1'b0; prev_ifv = 1'b0; prev_dmv = 1'b0;
        glog = "";
        ram[32'h100]     = 32'h0050_0093;
        ref_mem[32'h100] = 32'h0050_0093;

        repeat (2) step();
        chk("rst_mem_req",   32'(mem_req), 32'd0);
        chk("rst_mem_we",    32'(mem_we), 32'd0);
        chk("rst_mem_addr",  mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_be",    32'(mem_be), 32'd0);
        chk("rst_if_valid",  32'(if_valid), 32'd0);
        chk("rst_dm_valid",  32'(dm_valid), 32'd0);
        chk("rst_if_rdata",  if_rdata, 32'd0);
        chk("rst_dm_rdata",  dm_rdata, 32'd0);
        rst = 1'b0;

        fork
            sampler();
            responder();
            monitor();
        join_none
        step();

        // Fetch only, memory answers one cycle after the request.
        do_fetch(32'h100, 2);
        chk("fetch_if_rdata", if_rdata, 32'h0050_0093);

        // Simultaneous requests: data first, then fetch.
        fork
            do_fetch(32'h104, 2);
            do_data(1'b0, 32'h2000, 32'd0, 4'h0, 2);
        join

        // Store: dm_rdata keeps the previous load value.
        do_data(1'b1, 32'h3004, 32'hDEAD_BEEF, 4'b0011, 2);
        chk("store_keeps_dm_rdata", dm_rdata, ref_rd(32'h2000));
        chk("store_reached_memory", ram_rd(32'h3004),
            merge(seed_word(32'h3004), 32'hDEAD_BEEF, 4'b0011));

        // Starvation guard: four data grants, then the waiting fetch.
        lat_min = 1; lat_max = 1;
        glog = "";
        fork
            do_fetch(32'h200, 2);
            begin
                for (int i = 0; i < 6; i++)
                    do_data(1'b0, 32'h2000 + 32'(i * 4), 32'd0, 4'h0, (i == 5) ? 2 : 0);
            end
        join
        tests++;
        if (glog != "DDDDIDD") begin
            errors++;
            $display("FAIL grant_order: got %s expected DDDDIDD", glog);
        end

        // Kill during a slow fetch: no valid pulse, if_rdata untouched.
        lat_min = 3; lat_max = 3;
        if_addr = 32'h300;
        if_req  = 1'b1;
        wait_mem_req(1'b1, "kill_grant");
        if_kill = 1'b1;
        step();
        if_kill = 1'b0;
        if_req  = 1'b0;
        wait_mem_req(1'b0, "kill_ack");
        chk("kill_no_valid", 32'(if_valid), 32'd0);
        chk("kill_if_rdata", if_rdata, last_if_q);
        repeat (2) step();
        do_fetch(32'h304, 2);
        chk("after_kill_fetch", if_rdata, ref_rd(32'h304));

        // Reset while a load waits for its ack; a late ack is ignored.
        resp_en = 1'b0;
        dm_we = 1'b0; dm_addr = 32'h2040; dm_be = 4'h0; dm_req = 1'b1;
        wait_mem_req(1'b1, "rstmid_grant");
        step();
        rst = 1'b1;
        dm_req = 1'b0;
        step();
        rst = 1'b0;
        last_if_q = '0; last_dm_q = '0;
        chk("rstmid_mem_req",  32'(mem_req), 32'd0);
        chk("rstmid_dm_valid", 32'(dm_valid), 32'd0);
        chk("rstmid_dm_rdata", dm_rdata, 32'd0);
        stray_ack = 1'b1;
        repeat (2) step();
        stray_ack = 1'b0;
        repeat (2) step();
        chk("stray_ack_no_dm_valid", 32'(dm_valid), 32'd0);
        chk("stray_ack_no_if_valid", 32'(if_valid), 32'd0);
        resp_en = 1'b1;
        lat_min = 0; lat_max = 0;
        do_fetch(32'h108, 2);

        // Random traffic from both requesters with random memory latency.
        lat_min = 0; lat_max = 3;
        fork
            begin
                for (int i = 0; i < 30; i++)
                    do_fetch(32'($urandom_range(1023, 0)) << 2, int'($urandom_range(2, 0)));
                if_req = 1'b0;
            end
            begin
                for (int i = 0; i < 30; i++)
                    do_data(1'($urandom_range(1, 0)),
                            32'h2000 + (32'($urandom_range(7, 0)) << 2),
                            $urandom(), 4'($urandom_range(15, 1)),
                            int'($urandom_range(2, 0)));
                dm_req = 1'b0;
            end
        join

        repeat (5) step();
        chk("exp_if_drained", 32'(exp_if.size()), 32'd0);
        chk("exp_dm_drained", 32'(exp_dm.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
